// File: rtl/dla_mosi_requester.sv
// DLA-side MOSI requester: frames DLA requests as header + write beats toward the MOSI bridge
// and buffers MISO read beats back into the DLA read-return stream, with a progress watchdog.
module dla_mosi_requester #(
    parameter int MOSI_DATA_W = 256,
    parameter int TIMEOUT_CYC = 1024,
    parameter int RBUF_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [31:0]            req_addr_i,
    input  logic [7:0]             req_len_i,
    input  logic                   wdat_valid_i,
    output logic                   wdat_ready_o,
    input  logic [MOSI_DATA_W-1:0] wdat_data_i,
    output logic                   rdat_valid_o,
    input  logic                   rdat_ready_i,
    output logic [MOSI_DATA_W-1:0] rdat_data_o,
    output logic                   done_o,
    output logic [1:0]             err_o,
    output logic                   mosi_valid_o,
    input  logic                   mosi_ready_i,
    output logic [MOSI_DATA_W-1:0] mosi_data_o,
    input  logic                   miso_valid_i,
    output logic                   miso_ready_o,
    input  logic [MOSI_DATA_W-1:0] miso_data_i
);

    localparam int PTR_W = $clog2(RBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   write_q, write_d;
    logic [7:0]             len_q, len_d;
    logic [8:0]             beat_q, beat_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [1:0]             err_q, err_d, err_set;
    logic                   done_q, done_d;
    logic [MOSI_DATA_W-1:0] hdr_q, hdr_d;
    logic                   hdr_load;
    logic [MOSI_DATA_W-1:0] mem_q [RBUF_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       fill_q, fill_d;
    logic                   push, pop, drop, flush;
    logic                   mosi_hs, miso_hs, rdat_hs, req_ok;

    assign mosi_hs = mosi_valid_o & mosi_ready_i;
    assign miso_hs = miso_valid_i & miso_ready_o;
    assign rdat_hs = rdat_valid_o & rdat_ready_i;
    assign req_ok  = req_len_i[0] && (req_addr_i[5:0] == 6'd0);

    // A beat may still land in the slack slot after ready drops; only a full buffer with no pop drops it
    assign pop  = rdat_hs;
    assign push = (state_q == S_RDATA) && miso_valid_i && ((fill_q != CNT_W'(RBUF_DEPTH)) || pop);
    assign drop = (state_q == S_RDATA) && miso_valid_i && (fill_q == CNT_W'(RBUF_DEPTH)) && !pop;

    always_comb begin
        req_ready_o  = (state_q == S_IDLE) && (err_q == 2'b00) && !done_q;
        mosi_valid_o = 1'b0;
        mosi_data_o  = '0;
        wdat_ready_o = 1'b0;
        miso_ready_o = 1'b0;
        case (state_q)
            S_HDR: begin
                mosi_valid_o = 1'b1;
                mosi_data_o  = hdr_q;
            end
            S_WDATA: begin
                mosi_valid_o = wdat_valid_i;
                mosi_data_o  = wdat_data_i;
                wdat_ready_o = mosi_ready_i;
            end
            S_WDONE: miso_ready_o = 1'b1;
            S_RDATA: miso_ready_o = (fill_q <= CNT_W'(RBUF_DEPTH - 2));
            default: ;
        endcase
        rdat_valid_o = (fill_q != '0);
        rdat_data_o  = rdat_valid_o ? mem_q[rd_ptr_q] : '0;
        done_o       = done_q;
        err_o        = err_q;
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        len_d    = len_q;
        beat_d   = beat_q;
        wd_d     = '0;
        err_set  = 2'b00;
        done_d   = 1'b0;
        flush    = 1'b0;
        hdr_load = 1'b0;
        hdr_d    = '0;
        hdr_d[1:0]   = req_write_i ? 2'b01 : 2'b10;
        hdr_d[9:2]   = req_len_i;
        hdr_d[41:10] = req_addr_i;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    if (req_ok) begin
                        hdr_load = 1'b1;
                        write_d  = req_write_i;
                        len_d    = req_len_i;
                        beat_d   = '0;
                        state_d  = S_HDR;
                    end else begin
                        err_set[0] = 1'b1;
                    end
                end
            end
            S_HDR: if (mosi_hs) state_d = write_q ? S_WDATA : S_RDATA;
            S_WDATA: begin
                if (mosi_hs) begin
                    if (beat_q == {1'b0, len_q}) begin
                        beat_d  = '0;
                        state_d = S_WDONE;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            S_WDONE: begin
                if (miso_valid_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (push) beat_d = beat_q + 9'd1;
                if (drop) err_set[1] = 1'b1;
                if ((beat_q == {1'b0, len_q} + 9'd1) && (fill_q == '0)) begin
                    beat_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog: any handshake counts as progress; expiry aborts without a done pulse
        if ((state_q == S_WDATA) || (state_q == S_WDONE) || (state_q == S_RDATA)) begin
            if (mosi_hs || miso_hs || rdat_hs) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                err_set[1] = 1'b1;
                flush      = 1'b1;
                done_d     = 1'b0;
                beat_d     = '0;
                state_d    = S_IDLE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
        err_d = clr_i ? 2'b00 : (err_q | err_set);
    end

    always_comb begin
        fill_d = fill_q;
        if (flush)            fill_d = '0;
        else if (push && !pop) fill_d = fill_q + CNT_W'(1);
        else if (pop && !push) fill_d = fill_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            len_q    <= '0;
            beat_q   <= '0;
            wd_q     <= '0;
            err_q    <= 2'b00;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            done_q  <= done_d;
            fill_q  <= fill_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (hdr_load) hdr_q <= hdr_d;
        if (push)     mem_q[wr_ptr_q] <= miso_data_i;
    end

endmodule

// File: tb/tb_dla_mosi_requester.sv
// Scoreboard bench for dla_mosi_requester: expected MOSI beats, read returns and done pulses are
// queued by the stimulus thread and retired by a monitor that watches the DUT handshakes.
module tb_dla_mosi_requester;

    localparam int DW = 64;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_i;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [31:0]   req_addr_i;
    logic [7:0]    req_len_i;
    logic          wdat_valid_i, wdat_ready_o;
    logic [DW-1:0] wdat_data_i;
    logic          rdat_valid_o, rdat_ready_i;
    logic [DW-1:0] rdat_data_o;
    logic          done_o;
    logic [1:0]    err_o;
    logic          mosi_valid_o, mosi_ready_i;
    logic [DW-1:0] mosi_data_o;
    logic          miso_valid_i, miso_ready_o;
    logic [DW-1:0] miso_data_i;

    dla_mosi_requester #(.MOSI_DATA_W(DW), .TIMEOUT_CYC(TO), .RBUF_DEPTH(4)) dut (
        .clk_i(clk), .rst_n(rst_n), .clr_i(clr_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_data_i(wdat_data_i),
        .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_data_o(rdat_data_o),
        .done_o(done_o), .err_o(err_o),
        .mosi_valid_o(mosi_valid_o), .mosi_ready_i(mosi_ready_i), .mosi_data_o(mosi_data_o),
        .miso_valid_i(miso_valid_i), .miso_ready_o(miso_ready_o), .miso_data_i(miso_data_i)
    );

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_bad = 0;
    int            done_exp = 0;
    int            done_seen = 0;
    logic [DW-1:0] mosi_q[$];
    logic [DW-1:0] rdat_q[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mon_loop;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && mosi_valid_o) chk("mosi_stable", mosi_data_o, prev_data);
                if (mosi_valid_o && mosi_ready_i) begin
                    if (mosi_q.size() == 0) chk("mosi_extra", mosi_data_o, 'x);
                    else begin
                        e = mosi_q.pop_front();
                        chk("mosi_beat", mosi_data_o, e);
                    end
                end
                prev_stall = mosi_valid_o && !mosi_ready_i;
                prev_data  = mosi_data_o;
                if (rdat_valid_o && rdat_ready_i) begin
                    if (rdat_q.size() == 0) chk("rdat_extra", rdat_data_o, 'x);
                    else begin
                        e = rdat_q.pop_front();
                        chk("rdat_beat", rdat_data_o, e);
                    end
                end
                if (done_o) begin
                    chk("done_expected", DW'(done_seen < done_exp), DW'(1));
                    done_seen++;
                end
            end
        end
    endtask

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_len_i   = len;
        for (int i = 0; i < 50; i++) begin
            if (req_ready_o) begin
                tick;
                req_valid_i = 1'b0;
                return;
            end
            tick;
        end
        req_valid_i = 1'b0;
        chk("req_accept_timeout", 0, 1);
    endtask

    task automatic put_beat(input logic [DW-1:0] d, input bit tog);
        wdat_valid_i = 1'b1;
        wdat_data_i  = d;
        mosi_q.push_back(d);
        for (int i = 0; i < 50; i++) begin
            if (tog) mosi_ready_i = ~mosi_ready_i;
            #1;
            if (wdat_ready_o) begin
                tick;
                wdat_valid_i = 1'b0;
                return;
            end
            tick;
        end
        wdat_valid_i = 1'b0;
        chk("wbeat_timeout", 0, 1);
    endtask

    task automatic miso_pulse(input logic [DW-1:0] d);
        miso_valid_i = 1'b1;
        miso_data_i  = d;
        tick;
        miso_valid_i = 1'b0;
    endtask

    task automatic wait_miso_ready(input int max);
        for (int i = 0; i < max; i++) begin
            if (miso_ready_o) return;
            tick;
        end
        chk("miso_ready_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            if (done_seen >= done_exp) return;
            tick;
        end
        chk("done_timeout", DW'(done_seen), DW'(done_exp));
    endtask

    task automatic clear_err;
        clr_i = 1'b1;
        tick;
        clr_i = 1'b0;
    endtask

    task automatic stimulus;
        rst_n = 1'b0; clr_i = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        wdat_valid_i = 1'b0; wdat_data_i = '0; rdat_ready_i = 1'b0;
        mosi_ready_i = 1'b1; miso_valid_i = 1'b0; miso_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", DW'(req_ready_o), 1);
        chk("rst_wdat_ready", DW'(wdat_ready_o), 0);
        chk("rst_rdat_valid", DW'(rdat_valid_o), 0);
        chk("rst_done", DW'(done_o), 0);
        chk("rst_err", DW'(err_o), 0);
        chk("rst_mosi_valid", DW'(mosi_valid_o), 0);
        chk("rst_miso_ready", DW'(miso_ready_o), 0);
        chk("rst_mosi_data", mosi_data_o, 0);
        chk("rst_rdat_data", rdat_data_o, 0);
        rst_n = 1'b1;
        tick;

        // write addr 0x40 len 3, no backpressure
        mosi_q.push_back(64'h1000D);
        send_req(1'b1, 32'h40, 8'd3);
        for (int b = 0; b < 4; b++) put_beat(64'hA5A5_0000 + DW'(b), 1'b0);
        chk("wdone_miso_ready", DW'(miso_ready_o), 1);
        done_exp++;
        miso_pulse('0);
        chk("wr_done_pulse", DW'(done_o), 1);
        chk("ready_low_during_done", DW'(req_ready_o), 0);
        tick;
        chk("wr_done_one_cycle", DW'(done_o), 0);
        chk("ready_after_done", DW'(req_ready_o), 1);
        chk("wr_err", DW'(err_o), 0);

        // read addr 0x80 len 1, returns held off then drained
        mosi_q.push_back(64'h20006);
        send_req(1'b0, 32'h80, 8'd1);
        wait_miso_ready(20);
        miso_pulse(64'hA);
        miso_pulse(64'hB);
        chk("rd_valid_buffered", DW'(rdat_valid_o), 1);
        chk("rd_head", rdat_data_o, 64'hA);
        chk("rd_ready_occ2", DW'(miso_ready_o), 1);
        rdat_q.push_back(64'hA);
        rdat_q.push_back(64'hB);
        done_exp++;
        rdat_ready_i = 1'b1;
        wait_done(20);
        rdat_ready_i = 1'b0;
        chk("rd_err", DW'(err_o), 0);

        // read len 3: ready drops at occupancy 3, slack beat still accepted
        mosi_q.push_back(64'h8000E);
        send_req(1'b0, 32'h200, 8'd3);
        wait_miso_ready(20);
        for (int b = 1; b <= 3; b++) miso_pulse(DW'(b));
        chk("ready_drop_occ3", DW'(miso_ready_o), 0);
        miso_pulse(64'h4);
        chk("slack_no_err", DW'(err_o), 0);
        for (int b = 1; b <= 4; b++) rdat_q.push_back(DW'(b));
        done_exp++;
        rdat_ready_i = 1'b1;
        wait_done(20);
        rdat_ready_i = 1'b0;

        // malformed requests
        send_req(1'b1, 32'h40, 8'd2);
        chk("bad_len_err", DW'(err_o), 1);
        chk("bad_len_ready", DW'(req_ready_o), 0);
        repeat (3) tick;
        chk("bad_len_no_mosi", DW'(mosi_valid_o), 0);
        clear_err;
        chk("clr_err", DW'(err_o), 0);
        chk("clr_ready", DW'(req_ready_o), 1);
        send_req(1'b0, 32'h41, 8'd1);
        chk("bad_addr_err", DW'(err_o), 1);
        clear_err;

        // timeout in WDATA
        mosi_q.push_back(64'h10005);
        send_req(1'b1, 32'h40, 8'd1);
        tick;
        repeat (TO - 1) tick;
        chk("pre_timeout_err", DW'(err_o), 0);
        tick;
        chk("timeout_err", DW'(err_o), 2);
        chk("timeout_idle_wready", DW'(wdat_ready_o), 0);
        chk("timeout_idle_mosi", DW'(mosi_valid_o), 0);
        chk("timeout_no_done", DW'(done_o), 0);
        clear_err;

        // backpressure during header and data
        mosi_q.push_back(64'h40005);
        mosi_ready_i = 1'b1;
        send_req(1'b1, 32'h100, 8'd1);
        put_beat(64'hBEEF_0001, 1'b1);
        put_beat(64'hBEEF_0002, 1'b1);
        mosi_ready_i = 1'b1;
        chk("bp_in_wdone", DW'(miso_ready_o), 1);
        done_exp++;
        miso_pulse('0);
        chk("bp_done", DW'(done_o), 1);
        tick;

        // async reset mid-RDATA with two buffered beats
        mosi_q.push_back(64'h3000E);
        send_req(1'b0, 32'hC0, 8'd3);
        wait_miso_ready(20);
        miso_pulse(64'h55);
        miso_pulse(64'h66);
        chk("pre_rst_rvalid", DW'(rdat_valid_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", DW'(rdat_valid_o), 0);
        chk("async_rst_rdata", rdat_data_o, 0);
        chk("async_rst_miso_ready", DW'(miso_ready_o), 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_ready", DW'(req_ready_o), 1);
        chk("post_rst_err", DW'(err_o), 0);

        tick;
        chk("mosi_q_drained", DW'(mosi_q.size()), 0);
        chk("rdat_q_drained", DW'(rdat_q.size()), 0);
        chk("done_count", DW'(done_seen), DW'(done_exp));
    endtask

    initial begin
        fork
            mon_loop();
            begin
                stimulus();
                $display("test done: total=%0d bad=%0d", n_total, n_bad);
                $finish;
            end
            begin
                #200000;
                $display("FAIL global_timeout got=running want=finished");
                $fatal(1, "bench timeout");
            end
        join_any
    end

endmodule

// File: doc/dla_mosi_requester.md
# dla_mosi_requester

Upstream front end of the DLA-to-DDR path. Accepts DLA transfer requests (direction, byte address, burst length) with write data. Frames each request as a MOSI header word followed by payload beats toward the MOSI-to-native bridge, and collects MISO read beats and write-done pulses back into a buffered DLA read-return stream. Malformed requests are rejected locally, and stalled transfers are caught by a progress watchdog.

## Interface
Parameters:
- MOSI_DATA_W, 256, width of MOSI/MISO beats and of DLA write/read data
- TIMEOUT_CYC, 1024, maximum number of cycles without a handshake in WDATA/WDONE/RDATA before abort
- RBUF_DEPTH, 4, read-return buffer entries (power of two)

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr_i  in  1  clears sticky error flags
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  DLA byte address
- req_len_i  in  8  burst length in beats, minus 1
- wdat_valid_i / wdat_ready_o  in/out  1  write-data handshake
- wdat_data_i  in  MOSI_DATA_W  write payload
- rdat_valid_o / rdat_ready_i  out/in  1  read-return handshake
- rdat_data_o  out  MOSI_DATA_W  read payload
- done_o  out  1  one-cycle pulse when a transfer completes
- err_o  out  2  sticky; [0] = rejected request, [1] = timeout
- mosi_valid_o / mosi_ready_i  out/in  1  MOSI handshake
- mosi_data_o  out  MOSI_DATA_W  header or write beat
- miso_valid_i / miso_ready_o  in/out  1  MISO beat or write-done pulse
- miso_data_i  in  MOSI_DATA_W  read beat

## Operation
- Header word: [1:0] direction (2'b01 write, 2'b10 read), [9:2] req_len_i, [41:10] req_addr_i; all other bits 0.
- FSM states: IDLE, HDR, WDATA, WDONE, RDATA.
- IDLE:
  - req_ready_o = (err_o == 0).
  - On request handshake, validate the request. It is valid only if req_len_i[0] == 1 (even beat count) and req_addr_i[5:0] == 0.
  - Invalid request: consumed, err_o[0] set, stay in IDLE, no done_o.
  - Valid request: register the header, then go to HDR.
- HDR:
  - mosi_valid_o = 1, mosi_data_o = header.
  - On mosi_ready_i, go to WDATA (write) or RDATA (read).
- WDATA:
  - Combinational pass-through: mosi_valid_o = wdat_valid_i, mosi_data_o = wdat_data_i, wdat_ready_o = mosi_ready_i.
  - 9-bit beat counter; after req_len+1 handshakes, go to WDONE.
- WDONE:
  - miso_ready_o = 1.
  - Any miso_valid_i is the done pulse, taken regardless of ready; then done_o and IDLE.
- RDATA:
  - miso_ready_o = 1 while buffer occupancy ≤ RBUF_DEPTH-2. This gives one slot of slack, because downstream may present a beat one cycle after ready drops.
  - Every miso_valid_i & miso_ready_o pushes miso_data_i into the buffer.
  - A MISO beat arriving while the buffer is full is dropped and sets err_o[1].
  - After req_len+1 beats pushed and the buffer empty, pulse done_o and go to IDLE.
- Read buffer: FIFO; rdat_valid_o = not empty, rdat_data_o = head entry. Simultaneous push and pop keeps the count unchanged, including when the buffer is full.
- Watchdog:
  - Counts while in WDATA/WDONE/RDATA and reloads to 0 on any mosi, miso or rdat handshake.
  - At TIMEOUT_CYC: set err_o[1], flush the buffer, go to IDLE, no done_o.
- clr_i clears err_o and has priority over a same-cycle error set. It does not affect an in-flight transfer.
- Idle outputs: mosi_valid_o, wdat_ready_o and miso_ready_o are 0 outside their states.

## Timing
- Reset values: FSM in IDLE; req_ready_o 1; wdat_ready_o, rdat_valid_o, done_o, mosi_valid_o and miso_ready_o 0; err_o 2'b00; mosi_data_o and rdat_data_o 0; all counters and buffer pointers 0.
- Latency: request handshake at cycle N → header valid at N+1. A write with zero backpressure issues its first data beat at N+2.
- done_o is asserted the cycle after the completing event: the miso pulse in WDONE, or buffer-empty in RDATA.
- The header is held stable while mosi_valid_o=1 and mosi_ready_i=0.
- Reset asserted mid-transfer returns the block to IDLE immediately, with the buffer emptied; the partial transfer is discarded.
- Back-to-back requests: the next req_ready_o rises the cycle after done_o.

## Test plan
- Write, addr 0x40, len 3: header 0x...0100_0D (addr 0x40 in [41:10], len 3 in [9:2], dir 2'b01 in [1:0]), then 4 data beats pass through. A miso pulse in WDONE → done_o for 1 cycle; err_o = 0.
- Read, addr 0x80, len 1: after the header, 2 miso beats (0xA, 0xB) arrive with rdat_ready_i=0 → buffer holds 2 and miso_ready_o drops at occupancy 3. Raising rdat_ready_i returns 0xA then 0xB, followed by done_o.
- Invalid requests: len 2 → err_o = 2'b01, no MOSI traffic, req_ready_o = 0. Assert clr_i → err_o = 0. addr 0x41 → err_o = 2'b01.
- Timeout: write len 1, hold wdat_valid_i = 0 for TIMEOUT_CYC cycles → err_o[1] = 1, FSM back in IDLE, no done_o.
- Backpressure: mosi_ready_i toggled 1/0 during HDR and WDATA → header and data stable while stalled, exactly len+1 beats counted.
- Async reset asserted mid-RDATA with 2 buffered beats → rdat_valid_o = 0 immediately; after release req_ready_o = 1.
